// File: rtl/aes_pkg.sv
// Shared AES constants, round-key word layout and GF(2^8) helpers used by the
// key schedule and the round stage.
package aes_pkg;

    localparam logic        KEYLEN_128 = 1'b0;
    localparam logic        KEYLEN_256 = 1'b1;
    localparam int unsigned NR_128     = 10;
    localparam int unsigned NR_256     = 14;
    localparam logic [7:0]  RCON_INIT  = 8'h01;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned RKEY_W = 128;
    localparam int unsigned KEY_W  = 256;
    localparam int unsigned ADDR_W = 4;

    // Round key as four 32-bit words; w0 occupies bits [127:96].
    typedef struct packed {
        logic [WORD_W-1:0] w0;
        logic [WORD_W-1:0] w1;
        logic [WORD_W-1:0] w2;
        logic [WORD_W-1:0] w3;
    } rkey_t;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_mem_regfile.sv
// Round-key store: NUM_KEYS x 128 with one write port that can optionally
// fill two consecutive entries (used to load both halves of a 256-bit key).
module aes_key_mem_regfile
    import aes_pkg::*;
#(
    parameter int unsigned NUM_KEYS = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              we_pair_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [KEY_W-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [RKEY_W-1:0] rdata_o
);

    logic [RKEY_W-1:0] mem_q [NUM_KEYS];
    logic [ADDR_W-1:0] waddr_pair;

    assign waddr_pair = waddr_i + ADDR_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NUM_KEYS); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_KEYS); i++) begin
                if (we_i && (waddr_i == ADDR_W'(i))) begin
                    mem_q[i] <= wdata_i[KEY_W-1:RKEY_W];
                end
                if (we_pair_i && (waddr_pair == ADDR_W'(i))) begin
                    mem_q[i] <= wdata_i[RKEY_W-1:0];
                end
            end
        end
    end

    // Addresses beyond the store read as zero.
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            if (raddr_i == ADDR_W'(i)) begin
                rdata_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/aes_key_mem.sv
// AES-128/256 key expansion: generates one round key per cycle through the
// shared S-box port and serves any stored round key by index.
module aes_key_mem
    import aes_pkg::*;
#(
    parameter int unsigned NUM_KEYS = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    input  logic [KEY_W-1:0]    key,
    input  logic                keylen,
    input  logic [ADDR_W-1:0]   round,
    output logic [RKEY_W-1:0]   round_key,
    output logic                ready,
    output logic [WORD_W-1:0]   sboxw,
    input  logic [WORD_W-1:0]   new_sboxw
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_GEN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic              keylen_q, keylen_d;
    logic              ready_q, ready_d;
    logic [7:0]        rcon_q, rcon_d;
    logic [ADDR_W-1:0] ctr_q, ctr_d;
    rkey_t             prev_q, prev_d;
    rkey_t             pprev_q, pprev_d;

    logic              rf_we;
    logic              rf_we_pair;
    logic [ADDR_W-1:0] rf_waddr;
    logic [KEY_W-1:0]  rf_wdata;
    logic [RKEY_W-1:0] rf_rdata;

    logic              is_256;
    logic              odd_256;
    logic [ADDR_W-1:0] last_round;
    logic [WORD_W-1:0] rotsub;
    logic [WORD_W-1:0] mix_word;
    rkey_t             base_key;
    rkey_t             new_key;

    aes_key_mem_regfile #(
        .NUM_KEYS (NUM_KEYS)
    ) u_regfile (
        .clk_i     (clk),
        .rst_i     (reset),
        .we_i      (rf_we),
        .we_pair_i (rf_we_pair),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata),
        .raddr_i   (round),
        .rdata_o   (rf_rdata)
    );

    // Next round key: AES-256 chains from two keys back, odd AES-256 steps skip rotate/rcon.
    always_comb begin
        is_256     = (keylen_q == KEYLEN_256);
        odd_256    = is_256 && ctr_q[0];
        last_round = is_256 ? ADDR_W'(NR_256) : ADDR_W'(NR_128);
        rotsub     = {new_sboxw[23:0], new_sboxw[31:24]};
        base_key   = is_256 ? pprev_q : prev_q;
        mix_word   = odd_256 ? new_sboxw : (rotsub ^ {rcon_q, 24'h0});
        new_key.w0 = base_key.w0 ^ mix_word;
        new_key.w1 = base_key.w1 ^ new_key.w0;
        new_key.w2 = base_key.w2 ^ new_key.w1;
        new_key.w3 = base_key.w3 ^ new_key.w2;
    end

    // Control: init always wins and restarts the expansion from scratch.
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        keylen_d   = keylen_q;
        ready_d    = ready_q;
        rcon_d     = rcon_q;
        ctr_d      = ctr_q;
        prev_d     = prev_q;
        pprev_d    = pprev_q;
        rf_we      = 1'b0;
        rf_we_pair = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;

        if (init) begin
            key_d    = key;
            keylen_d = keylen;
            ready_d  = 1'b0;
            rcon_d   = RCON_INIT;
            state_d  = ST_INIT;
        end else begin
            case (state_q)
                ST_INIT: begin
                    rf_we    = 1'b1;
                    rf_waddr = '0;
                    rf_wdata = key_q;
                    if (is_256) begin
                        rf_we_pair = 1'b1;
                        pprev_d    = key_q[KEY_W-1:RKEY_W];
                        prev_d     = key_q[RKEY_W-1:0];
                        ctr_d      = ADDR_W'(2);
                    end else begin
                        prev_d     = key_q[KEY_W-1:RKEY_W];
                        ctr_d      = ADDR_W'(1);
                    end
                    state_d = ST_GEN;
                end
                ST_GEN: begin
                    rf_we    = 1'b1;
                    rf_waddr = ctr_q;
                    rf_wdata = {new_key, RKEY_W'(0)};
                    pprev_d  = prev_q;
                    prev_d   = new_key;
                    ctr_d    = ctr_q + ADDR_W'(1);
                    if (!odd_256) begin
                        rcon_d = xtime(rcon_q);
                    end
                    if (ctr_q == last_round) begin
                        ready_d = 1'b1;
                        state_d = ST_DONE;
                    end
                end
                ST_IDLE, ST_DONE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            key_q    <= '0;
            keylen_q <= KEYLEN_128;
            ready_q  <= 1'b1;
            rcon_q   <= RCON_INIT;
            ctr_q    <= '0;
            prev_q   <= '0;
            pprev_q  <= '0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            keylen_q <= keylen_d;
            ready_q  <= ready_d;
            rcon_q   <= rcon_d;
            ctr_q    <= ctr_d;
            prev_q   <= prev_d;
            pprev_q  <= pprev_d;
        end
    end

    assign ready     = ready_q;
    assign sboxw     = prev_q.w3;
    assign round_key = (round <= last_round) ? rf_rdata : '0;

endmodule

// File: tb/tb_aes_key_mem.sv
// Scoreboard bench for aes_key_mem using FIPS-197 key schedule vectors and a
// combinational S-box model on the shared word port.
module tb_aes_key_mem;

    localparam int SEL_KEY   = 0;
    localparam int SEL_READY = 1;
    localparam int SEL_SBOXW = 2;

    localparam logic [255:0] K_FIPS   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K_SEQ128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K_SEQ256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         init = 1'b0;
    logic [255:0] key = '0;
    logic         keylen = 1'b0;
    logic [3:0]   round = '0;
    logic [127:0] round_key;
    logic         ready;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;

    string        name_q[$];
    int           sel_q[$];
    logic [127:0] val_q[$];
    int           lat_q[$];
    logic         chk = 1'b0;
    logic         done = 1'b0;
    int           since_init = 1000;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] sb(input logic [7:0] x);
        int idx;
        idx = (255 - int'(x)) * 8;
        return SBOX[idx +: 8];
    endfunction

    assign new_sboxw = {sb(sboxw[31:24]), sb(sboxw[23:16]), sb(sboxw[15:8]), sb(sboxw[7:0])};

    aes_key_mem dut (
        .clk       (clk),
        .reset     (reset),
        .init      (init),
        .key       (key),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .ready     (ready),
        .sboxw     (sboxw),
        .new_sboxw (new_sboxw)
    );

    // Edges elapsed since the last sampled init pulse.
    initial forever begin
        @(posedge clk);
        if (init) since_init = 0;
        else if (since_init < 1000) since_init = since_init + 1;
    end

    // Monitor: sampled outputs, ready latency and end-of-run leftovers.
    initial begin : monitor
        logic         armed;
        logic         end_seen;
        string        n;
        int           s;
        int           el;
        logic [127:0] e;
        logic [127:0] a;
        armed    = 1'b0;
        end_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (chk) begin
                checks++;
                if (val_q.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard_underflow: got sample with no expectation, required one queued");
                end else begin
                    n = name_q.pop_front();
                    s = sel_q.pop_front();
                    e = val_q.pop_front();
                    case (s)
                        SEL_READY: a = {127'h0, ready};
                        SEL_SBOXW: a = {96'h0, sboxw};
                        default:   a = round_key;
                    endcase
                    if (a !== e) begin
                        failures++;
                        $display("FAIL %s: got %h required %h", n, a, e);
                    end
                end
            end
            if (reset) armed = 1'b0;
            else if (since_init == 0) armed = 1'b1;
            if (armed && ready) begin
                armed = 1'b0;
                checks++;
                if (lat_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ready: got ready after %0d edges, required none", since_init);
                end else begin
                    el = lat_q.pop_front();
                    if (since_init != el) begin
                        failures++;
                        $display("FAIL ready_latency: got %0d edges required %0d", since_init, el);
                    end
                end
            end
            if (done && !end_seen) begin
                end_seen = 1'b1;
                checks++;
                if (val_q.size() != 0 || lat_q.size() != 0) begin
                    failures++;
                    $display("FAIL leftover_expectations: got %0d samples %0d latencies pending, required 0 0",
                             val_q.size(), lat_q.size());
                end
            end
        end
    end

    task automatic sample(input string n, input int s, input logic [3:0] r, input logic [127:0] e);
        round = r;
        name_q.push_back(n);
        sel_q.push_back(s);
        val_q.push_back(e);
        chk = 1'b1;
        @(negedge clk);
        #1;
        chk = 1'b0;
    endtask

    task automatic start(input logic kl, input logic [255:0] k, input int lat);
        @(posedge clk);
        #1;
        key    = k;
        keylen = kl;
        init   = 1'b1;
        if (lat > 0) lat_q.push_back(lat);
        @(posedge clk);
        #1;
        init = 1'b0;
    endtask

    task automatic wait_ready(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ready) break;
        end
        #1;
    endtask

    initial begin : driver
        repeat (2) @(posedge clk);
        #1;
        sample("rst_ready", SEL_READY, 4'd0, 128'h1);
        sample("rst_sboxw", SEL_SBOXW, 4'd0, 128'h0);
        sample("rst_rk0", SEL_KEY, 4'd0, 128'h0);
        reset = 1'b0;
        sample("post_rst_ready", SEL_READY, 4'd0, 128'h1);

        start(1'b0, K_FIPS, 11);
        wait_ready(40);
        sample("fips128_r0", SEL_KEY, 4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        sample("fips128_r1", SEL_KEY, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
        sample("fips128_r2", SEL_KEY, 4'd2, 128'hf2c295f27a96b9435935807a7359f67f);
        sample("fips128_r10", SEL_KEY, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        sample("fips128_r11", SEL_KEY, 4'd11, 128'h0);

        start(1'b0, K_SEQ128, 11);
        wait_ready(40);
        sample("seq128_r0", SEL_KEY, 4'd0, 128'h000102030405060708090a0b0c0d0e0f);
        sample("seq128_r10", SEL_KEY, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        start(1'b1, K_SEQ256, 14);
        wait_ready(40);
        sample("seq256_r0", SEL_KEY, 4'd0, 128'h000102030405060708090a0b0c0d0e0f);
        sample("seq256_r1", SEL_KEY, 4'd1, 128'h101112131415161718191a1b1c1d1e1f);
        sample("seq256_r2", SEL_KEY, 4'd2, 128'ha573c29fa176c498a97fce93a572c09c);
        sample("seq256_r14", SEL_KEY, 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        sample("seq256_r15", SEL_KEY, 4'd15, 128'h0);

        // Second init lands on the fifth edge after the first.
        start(1'b1, K_SEQ256, 0);
        repeat (3) @(posedge clk);
        start(1'b0, K_FIPS, 11);
        wait_ready(40);
        sample("restart_r10", SEL_KEY, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        sample("restart_r11", SEL_KEY, 4'd11, 128'h0);

        // Back-to-back: new init issued as soon as ready is seen high.
        start(1'b0, K_SEQ128, 11);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) break;
        end
        #1;
        key    = K_FIPS;
        keylen = 1'b0;
        init   = 1'b1;
        lat_q.push_back(11);
        @(posedge clk);
        #1;
        init = 1'b0;
        sample("b2b_ready_drop", SEL_READY, 4'd0, 128'h0);
        wait_ready(40);
        sample("b2b_r0", SEL_KEY, 4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        sample("b2b_r10", SEL_KEY, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        start(1'b0, K_FIPS, 0);
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        sample("midrst_ready", SEL_READY, 4'd0, 128'h1);
        sample("midrst_sboxw", SEL_SBOXW, 4'd0, 128'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int r = 0; r < 15; r++) begin
            sample($sformatf("midrst_r%0d", r), SEL_KEY, 4'(r), 128'h0);
        end

        done = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
